merge_dispatch_noc: RTL and testbench

MERGE_DISPATCH_NOC -- requirements
Module: merge_dispatch_noc

---
 rtl/merge_dispatch_noc_pkg.sv | 22 ++
 rtl/rr_fifo_node.sv | 70 +++++++
 rtl/merge_dispatch_noc.sv | 98 +++++++++
 tb/tb_merge_dispatch_noc.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/merge_dispatch_noc_pkg.sv
// Shared sizing and slicing helpers for the merge/dispatch tree.
// Each tree entry is packed as {addr, data}.
package merge_dispatch_noc_pkg;

  function automatic int entry_w(input int bit_width, input int addr_w);
    return bit_width + addr_w;
  endfunction

  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

  function automatic int n_nodes(input int log_n_in);
    return (1 << log_n_in) - 1;
  endfunction

  // Heap-ordered tree: node 0 is the root, children of k are 2k+1 / 2k+2.
  function automatic int first_leaf(input int log_n_in);
    return (1 << (log_n_in - 1)) - 1;
  endfunction

endpackage

// File: rtl/rr_fifo_node.sv
// Two-input round-robin arbiter feeding a DEPTH-entry FIFO.
// The grant doubles as the pop of the selected child.
module rr_fifo_node #(
  parameter int ENTRY_W   = 19,
  parameter int LOG_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ENTRY_W-1:0] ch0_entry,
  input  logic               ch0_valid,
  input  logic [ENTRY_W-1:0] ch1_entry,
  input  logic               ch1_valid,
  output logic [1:0]         grant,
  output logic [ENTRY_W-1:0] head_entry,
  output logic               head_valid,
  input  logic               pop
);

  localparam int DEPTH = 1 << LOG_DEPTH;
  localparam logic [LOG_DEPTH:0] DEPTH_C = (LOG_DEPTH + 1)'(DEPTH);

  logic [ENTRY_W-1:0]   mem [DEPTH];
  logic [LOG_DEPTH-1:0] wptr, rptr;
  logic [LOG_DEPTH:0]   count;
  logic                 prio;
  logic                 do_pop, has_space, push;
  logic [ENTRY_W-1:0]   push_entry;

  assign do_pop    = pop && (count != '0);
  assign has_space = (count < DEPTH_C) || do_pop;

  always_comb begin
    grant = 2'b00;
    if (rst && has_space) begin
      if (ch0_valid && ch1_valid) grant = prio ? 2'b10 : 2'b01;
      else if (ch0_valid)         grant = 2'b01;
      else if (ch1_valid)         grant = 2'b10;
    end
  end

  assign push       = |grant;
  assign push_entry = grant[1] ? ch1_entry : ch0_entry;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      prio  <= 1'b0;
    end else begin
      if (push)   wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Priority always moves to the child that was not just served.
      if (push) prio <= grant[0];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_entry;
  end

  assign head_entry = mem[rptr];
  assign head_valid = (count != '0);

endmodule

// File: rtl/merge_dispatch_noc.sv
// N_IN-to-N_OUT merge tree of rr_fifo_node instances with inline root dispatch.
// The root head's addr selects the single output presented each cycle.
module merge_dispatch_noc
  import merge_dispatch_noc_pkg::*;
#(
  parameter int BIT_WIDTH = 16,
  parameter int LOG_N_IN  = 3,
  parameter int LOG_N_OUT = 3,
  parameter int LOG_DEPTH = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [(2**LOG_N_IN)*BIT_WIDTH-1:0]  in_data,
  input  logic [(2**LOG_N_IN)*LOG_N_OUT-1:0]  in_addr,
  input  logic [(2**LOG_N_IN)-1:0]            in_valid,
  output logic [(2**LOG_N_IN)-1:0]            in_stall,
  output logic [(2**LOG_N_OUT)*BIT_WIDTH-1:0] out_data,
  output logic [(2**LOG_N_OUT)-1:0]           out_valid,
  input  logic [(2**LOG_N_OUT)-1:0]           out_ready
);

  localparam int N_IN       = 2 ** LOG_N_IN;
  localparam int ENTRY_W    = entry_w(BIT_WIDTH, LOG_N_OUT);
  localparam int N_NODES    = n_nodes(LOG_N_IN);
  localparam int FIRST_LEAF = first_leaf(LOG_N_IN);

  logic [ENTRY_W-1:0] node_head  [N_NODES];
  logic               node_valid [N_NODES];
  logic               node_pop   [N_NODES];
  logic [1:0]         node_grant [N_NODES];

  for (genvar k = 0; k < N_NODES; k++) begin : g_node
    logic [ENTRY_W-1:0] ch0_entry, ch1_entry;
    logic               ch0_valid, ch1_valid;

    if (k >= FIRST_LEAF) begin : g_leaf
      localparam int J = k - FIRST_LEAF;
      assign ch0_entry = {in_addr[slice_lo(2*J, LOG_N_OUT) +: LOG_N_OUT],
                          in_data[slice_lo(2*J, BIT_WIDTH) +: BIT_WIDTH]};
      assign ch1_entry = {in_addr[slice_lo(2*J+1, LOG_N_OUT) +: LOG_N_OUT],
                          in_data[slice_lo(2*J+1, BIT_WIDTH) +: BIT_WIDTH]};
      assign ch0_valid = in_valid[2*J];
      assign ch1_valid = in_valid[2*J+1];
    end else begin : g_inner
      assign ch0_entry = node_head[2*k+1];
      assign ch1_entry = node_head[2*k+2];
      assign ch0_valid = node_valid[2*k+1];
      assign ch1_valid = node_valid[2*k+2];
    end

    // A child's pop is its parent's grant on the matching side.
    if (k > 0) begin : g_pop
      assign node_pop[k] = node_grant[(k-1)/2][(k-1)%2];
    end

    rr_fifo_node #(
      .ENTRY_W   (ENTRY_W),
      .LOG_DEPTH (LOG_DEPTH)
    ) u_node (
      .clk        (clk),
      .rst        (rst),
      .ch0_entry  (ch0_entry),
      .ch0_valid  (ch0_valid),
      .ch1_entry  (ch1_entry),
      .ch1_valid  (ch1_valid),
      .grant      (node_grant[k]),
      .head_entry (node_head[k]),
      .head_valid (node_valid[k]),
      .pop        (node_pop[k])
    );
  end

  always_comb begin
    in_stall = '1;
    for (int j = 0; j < N_IN/2; j++) begin
      in_stall[2*j]   = ~node_grant[FIRST_LEAF+j][0];
      in_stall[2*j+1] = ~node_grant[FIRST_LEAF+j][1];
    end
  end

  logic [LOG_N_OUT-1:0] root_addr;
  logic [BIT_WIDTH-1:0] root_data;

  assign root_addr = node_head[0][ENTRY_W-1 -: LOG_N_OUT];
  assign root_data = node_head[0][BIT_WIDTH-1:0];

  always_comb begin
    out_valid = '0;
    out_data  = '0;
    if (node_valid[0]) begin
      out_valid[root_addr] = 1'b1;
      out_data[slice_lo(int'(root_addr), BIT_WIDTH) +: BIT_WIDTH] = root_data;
    end
  end

  assign node_pop[0] = node_valid[0] && out_ready[root_addr];

endmodule

// File: tb/tb_merge_dispatch_noc.sv
// Directed self-checking bench for merge_dispatch_noc at default parameters.
module tb_merge_dispatch_noc;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [127:0] in_data = '0;
  logic [23:0]  in_addr = '0;
  logic [7:0]   in_valid = '0;
  logic [7:0]   in_stall;
  logic [127:0] out_data;
  logic [7:0]   out_valid;
  logic [7:0]   out_ready = '1;

  int n_cmp = 0;
  int n_bad = 0;
  int acc_cnt [8];

  merge_dispatch_noc dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_addr   (in_addr),
    .in_valid  (in_valid),
    .in_stall  (in_stall),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [127:0] exp_vec(input int slot, input logic [15:0] d);
    logic [127:0] v;
    v = '0;
    v[slot*16 +: 16] = d;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst       = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    in_addr   = '0;
    out_ready = '1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    in_valid = 8'hFF;
    #3;
    n_cmp++;
    if (out_valid !== 8'h00) begin
      n_bad++; $display("FAIL reset_out_valid: got %h want 00", out_valid);
    end
    n_cmp++;
    if (in_stall !== 8'hFF) begin
      n_bad++; $display("FAIL reset_in_stall: got %h want ff", in_stall);
    end
    apply_reset();
  endtask

  task automatic test_latency();
    apply_reset();
    in_valid = 8'h01;
    in_addr[2:0] = 3'd5;
    in_data[15:0] = 16'h1234;
    @(negedge clk);
    n_cmp++;
    if (in_stall[0] !== 1'b0) begin
      n_bad++; $display("FAIL lat_accept: in_stall[0] got %b want 0", in_stall[0]);
    end
    tick();
    in_valid = '0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if (c < 3) begin
        if (out_valid !== 8'h00) begin
          n_bad++; $display("FAIL lat_early c=%0d: got %h want 00", c, out_valid);
        end
      end else begin
        if (out_valid !== 8'b0010_0000 || out_data !== exp_vec(5, 16'h1234)) begin
          n_bad++;
          $display("FAIL lat_arrive: valid %h data %h want 20 / %h", out_valid, out_data, exp_vec(5, 16'h1234));
        end
      end
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 8'h00) begin
      n_bad++; $display("FAIL lat_popped: got %h want 00", out_valid);
    end
  endtask

  task automatic test_alternate();
    int n0, n1, k;
    logic [7:0]  exp_stall, exp_valid;
    logic [127:0] exp_data;
    apply_reset();
    n0 = 0; n1 = 0;
    out_ready = 8'hFF;
    in_valid = 8'h03;
    in_addr[2:0] = 3'd1;
    in_addr[5:3] = 3'd2;
    for (int c = 0; c < 14; c++) begin
      in_data[15:0]  = 16'hA000 + 16'(n0);
      in_data[31:16] = 16'hB000 + 16'(n1);
      @(negedge clk);
      exp_stall = (c % 2 == 0) ? 8'b1111_1110 : 8'b1111_1101;
      n_cmp++;
      if (in_stall !== exp_stall) begin
        n_bad++; $display("FAIL alt_stall c=%0d: got %b want %b", c, in_stall, exp_stall);
      end
      if (c >= 3) begin
        k = c - 3;
        if (k % 2 == 0) begin
          exp_valid = 8'h02; exp_data = exp_vec(1, 16'hA000 + 16'(k/2));
        end else begin
          exp_valid = 8'h04; exp_data = exp_vec(2, 16'hB000 + 16'(k/2));
        end
        n_cmp++;
        if (out_valid !== exp_valid || out_data !== exp_data) begin
          n_bad++;
          $display("FAIL alt_out k=%0d: valid %h data %h want %h / %h", k, out_valid, out_data, exp_valid, exp_data);
        end
      end
      if (c % 2 == 0) n0++; else n1++;
      tick();
    end
    in_valid = '0;
  endtask

  task automatic test_fill();
    int accepted;
    logic [7:0] last_stall;
    apply_reset();
    out_ready = 8'h00;
    in_valid = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      in_addr[i*3 +: 3] = 3'(i);
      acc_cnt[i] = 0;
    end
    accepted = 0;
    last_stall = '0;
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < 8; i++)
        in_data[i*16 +: 16] = {4'(i), 12'(acc_cnt[i])};
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        if (!in_stall[i]) begin
          acc_cnt[i]++;
          accepted++;
        end
      end
      last_stall = in_stall;
      tick();
    end
    in_valid = '0;
    n_cmp++;
    if (accepted !== 28) begin
      n_bad++; $display("FAIL fill_count: accepted %0d want 28", accepted);
    end
    n_cmp++;
    if (last_stall !== 8'hFF) begin
      n_bad++; $display("FAIL fill_stall: got %h want ff", last_stall);
    end
    n_cmp++;
    if (out_valid === 8'h00 || (out_valid & (out_valid - 8'd1)) !== 8'h00) begin
      n_bad++; $display("FAIL fill_onehot: out_valid %h want one bit set", out_valid);
    end
  endtask

  task automatic test_drain();
    int nxt [8];
    int got, a, src;
    logic [15:0] d;
    for (int i = 0; i < 8; i++) nxt[i] = 0;
    got = 0;
    out_ready = 8'hFF;
    for (int c = 0; c < 34; c++) begin
      @(negedge clk);
      if (c < 28) begin
        n_cmp++;
        if (out_valid === 8'h00 || (out_valid & (out_valid - 8'd1)) !== 8'h00) begin
          n_bad++; $display("FAIL drain_valid c=%0d: out_valid %h want one bit set", c, out_valid);
        end else begin
          a = 0;
          for (int b = 0; b < 8; b++) if (out_valid[b]) a = b;
          d = out_data[a*16 +: 16];
          src = int'(d[15:12]);
          n_cmp++;
          if (src !== a || int'(d[11:0]) !== nxt[a]) begin
            n_bad++; $display("FAIL drain_order c=%0d: slot %0d data %h want %h", c, a, d, {4'(a), 12'(nxt[a])});
          end
          nxt[a]++;
          got++;
          n_cmp++;
          if ((out_data & ~exp_vec(a, 16'hFFFF)) !== 128'h0) begin
            n_bad++; $display("FAIL drain_other_zero c=%0d: out_data %h", c, out_data);
          end
        end
      end else begin
        n_cmp++;
        if (out_valid !== 8'h00) begin
          n_bad++; $display("FAIL drain_empty c=%0d: got %h want 00", c, out_valid);
        end
      end
      tick();
    end
    n_cmp++;
    if (got !== 28) begin
      n_bad++; $display("FAIL drain_total: got %0d want 28", got);
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (nxt[i] !== acc_cnt[i]) begin
        n_bad++; $display("FAIL drain_per_input %0d: delivered %0d want %0d", i, nxt[i], acc_cnt[i]);
      end
    end
  endtask

  task automatic test_hold();
    apply_reset();
    out_ready = 8'b1111_1011;
    in_valid = 8'h01;
    in_addr[2:0] = 3'd2;
    in_data[15:0] = 16'h0C0C;
    tick();
    in_valid = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c >= 3) begin
        n_cmp++;
        if (out_valid !== 8'h04 || out_data !== exp_vec(2, 16'h0C0C)) begin
          n_bad++; $display("FAIL hold c=%0d: valid %h data %h want 04 / %h", c, out_valid, out_data, exp_vec(2, 16'h0C0C));
        end
      end
    end
    tick();
    out_ready = 8'hFF;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 8'h04) begin
      n_bad++; $display("FAIL hold_release_pre: got %h want 04", out_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 8'h00) begin
      n_bad++; $display("FAIL hold_release_pop: got %h want 00", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    out_ready = 8'h00;
    in_valid = 8'h0F;
    for (int i = 0; i < 4; i++) begin
      in_addr[i*3 +: 3] = 3'd7;
      in_data[i*16 +: 16] = 16'hDEAD;
    end
    repeat (5) tick();
    in_valid = '0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 8'h80) begin
      n_bad++; $display("FAIL rmid_before: got %h want 80", out_valid);
    end
    #1 rst = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 8'h00) begin
      n_bad++; $display("FAIL rmid_immediate: got %h want 00", out_valid);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    out_ready = 8'hFF;
    in_valid = 8'b0000_1000;
    in_addr[11:9] = 3'd6;
    in_data[63:48] = 16'h5A5A;
    @(negedge clk);
    n_cmp++;
    if (in_stall[3] !== 1'b0) begin
      n_bad++; $display("FAIL rmid_accept: in_stall[3] got %b want 0", in_stall[3]);
    end
    tick();
    in_valid = '0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      n_cmp++;
      if (c == 3) begin
        if (out_valid !== 8'h40 || out_data !== exp_vec(6, 16'h5A5A)) begin
          n_bad++; $display("FAIL rmid_new: valid %h data %h want 40 / %h", out_valid, out_data, exp_vec(6, 16'h5A5A));
        end
      end else begin
        if (out_valid !== 8'h00) begin
          n_bad++; $display("FAIL rmid_stale c=%0d: got %h want 00", c, out_valid);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_alternate();
    test_fill();
    test_drain();
    test_hold();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
